// File: rtl/multicycle_control.sv
// Multicycle RISC-V style control FSM: sequences fetch, decode, memory, ALU,
// branch, jal and lui steps, flags illegal opcodes and counts retired instructions.
module multicycle_control #(
  parameter int WAIT_MEM = 1,
  parameter int EN_JAL   = 1,
  parameter int EN_LUI   = 1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             MemRead,
  output logic             AdrSrc,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  state_t           r_state;
  state_t           w_next;
  state_t           w_decState;
  logic             r_illegal;
  logic [CNT_W-1:0] r_retired;
  logic             w_memReady;
  logic             w_branchOk;
  logic             w_retire;

  // Without memory wait support every access completes in one cycle.
  assign w_memReady = (WAIT_MEM != 0) ? mem_ready : 1'b1;
  assign w_branchOk = (funct3 == 3'b000) || (funct3 == 3'b001);
  assign w_retire   = (w_next == S_FETCH) &&
                      ((r_state == S_MEMWB) || (r_state == S_MEMWRITE) ||
                       (r_state == S_ALUWB) || (r_state == S_BRANCH));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      if (w_retire) begin
        r_retired <= r_retired + CNT_W'(1);
      end
      if (w_next == S_TRAP) begin
        r_illegal <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_FETCH:    w_next = w_memReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if ((op == OP_LW) || (op == OP_SW)) w_next = S_MEMADR;
        else if (op == OP_RTYPE)            w_next = S_EXECR;
        else if (op == OP_ITYPE)            w_next = S_EXECI;
        else if (op == OP_BRANCH)           w_next = S_BRANCH;
        else if ((op == OP_JAL) && (EN_JAL != 0)) w_next = S_JAL;
        else if ((op == OP_LUI) && (EN_LUI != 0)) w_next = S_LUI;
        else                                w_next = S_TRAP;
      end
      S_MEMADR:   w_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  w_next = w_memReady ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: w_next = w_memReady ? S_FETCH : S_MEMWRITE;
      S_EXECR:    w_next = S_ALUWB;
      S_EXECI:    w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BRANCH:   w_next = w_branchOk ? S_FETCH : S_TRAP;
      S_JAL:      w_next = S_ALUWB;
      S_LUI:      w_next = S_ALUWB;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_TRAP;
    endcase
  end

  // While reset is held the datapath already sees the fetch controls.
  assign w_decState = reset ? S_FETCH : r_state;

  always_comb begin
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    MemRead   = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    unique case (w_decState)
      S_FETCH: begin
        MemRead   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = w_memReady;
        PCWrite   = w_memReady;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        MemRead = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        if (funct3 == 3'b000)      PCWrite = zero;
        else if (funct3 == 3'b001) PCWrite = ~zero;
        else                       PCWrite = 1'b0;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      S_LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
      end
      default: ;
    endcase
  end

  assign state   = r_state;
  assign illegal = r_illegal;
  assign retired = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench: each instruction is expanded into its expected
// state walk, and every cycle's state, strobes, flag and counter are compared.
module tb_multicycle_control;

  localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4,
                 MEMWRITE = 5, EXECR = 6, EXECI = 7, ALUWB = 8, BRANCH = 9,
                 JAL = 10, LUI = 11, TRAP = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       zero = 1'b0;
  logic       memReady = 1'b0;

  logic       aPCWrite, aIRWrite, aRegWrite, aMemWrite, aMemRead, aAdrSrc, aIllegal;
  logic [1:0] aResultSrc, aALUSrcA, aALUSrcB, aALUOp;
  logic [3:0] aState;
  logic [31:0] aRetired;
  logic       bPCWrite, bIRWrite, bRegWrite, bMemWrite, bMemRead, bAdrSrc, bIllegal;
  logic [1:0] bResultSrc, bALUSrcA, bALUSrcB, bALUOp;
  logic [3:0] bState;
  logic [3:0] bRetired;

  int assertCount = 0;
  int failCount   = 0;

  // Model configuration of whichever instance is under check.
  bit          useB = 0;
  bit          mWaitMem = 1, mEnJal = 1, mEnLui = 1;
  logic [31:0] mMask = 32'hFFFF_FFFF;
  logic [31:0] modelRetired = '0;

  int seqState[$];
  bit seqRdy[$];

  always #5 clk = ~clk;

  multicycle_control dutA (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .zero(zero), .mem_ready(memReady),
    .PCWrite(aPCWrite), .IRWrite(aIRWrite), .RegWrite(aRegWrite), .MemWrite(aMemWrite),
    .MemRead(aMemRead), .AdrSrc(aAdrSrc), .ResultSrc(aResultSrc), .ALUSrcA(aALUSrcA),
    .ALUSrcB(aALUSrcB), .ALUOp(aALUOp), .state(aState), .illegal(aIllegal), .retired(aRetired)
  );

  multicycle_control #(.WAIT_MEM(0), .EN_JAL(0), .EN_LUI(0), .CNT_W(4)) dutB (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .zero(zero), .mem_ready(memReady),
    .PCWrite(bPCWrite), .IRWrite(bIRWrite), .RegWrite(bRegWrite), .MemWrite(bMemWrite),
    .MemRead(bMemRead), .AdrSrc(bAdrSrc), .ResultSrc(bResultSrc), .ALUSrcA(bALUSrcA),
    .ALUSrcB(bALUSrcB), .ALUOp(bALUOp), .state(bState), .illegal(bIllegal), .retired(bRetired)
  );

  wire [13:0] aOuts = {aPCWrite, aIRWrite, aRegWrite, aMemWrite, aMemRead, aAdrSrc,
                       aResultSrc, aALUSrcA, aALUSrcB, aALUOp};
  wire [13:0] bOuts = {bPCWrite, bIRWrite, bRegWrite, bMemWrite, bMemRead, bAdrSrc,
                       bResultSrc, bALUSrcA, bALUSrcB, bALUOp};

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, observed, expected);
    end
  endtask

  // Strobe table {PCWrite,IRWrite,RegWrite,MemWrite,MemRead,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUOp}.
  function automatic logic [13:0] expOuts(input int s, input bit rdy, input bit z, input logic [2:0] f3);
    logic pcw, irw, rw, mw, mr, adr;
    logic [1:0] res, sa, sb, aop;
    bit r;
    r = mWaitMem ? rdy : 1'b1;
    {pcw, irw, rw, mw, mr, adr} = '0;
    {res, sa, sb, aop} = '0;
    case (s)
      FETCH:    begin mr = 1; sb = 2'b10; res = 2'b10; irw = r; pcw = r; end
      DECODE:   begin sa = 2'b01; sb = 2'b01; end
      MEMADR:   begin sa = 2'b10; sb = 2'b01; end
      MEMREAD:  begin adr = 1; mr = 1; end
      MEMWB:    begin res = 2'b01; rw = 1; end
      MEMWRITE: begin adr = 1; mw = 1; end
      EXECR:    begin sa = 2'b10; aop = 2'b10; end
      EXECI:    begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
      ALUWB:    rw = 1;
      BRANCH:   begin sa = 2'b10; aop = 2'b01; pcw = (f3 == 0) ? z : (f3 == 1) ? !z : 1'b0; end
      JAL:      begin sa = 2'b01; sb = 2'b10; pcw = 1; end
      LUI:      begin sa = 2'b11; sb = 2'b01; end
      default:  ;
    endcase
    return {pcw, irw, rw, mw, mr, adr, res, sa, sb, aop};
  endfunction

  task automatic pushPlain(input int s);
    seqState.push_back(s);
    seqRdy.push_back(1'($urandom_range(0, 1)));
  endtask

  // A memory-waiting state repeats once per low mem_ready cycle when waits are honoured.
  task automatic pushMem(input int s, input int waits);
    if (mWaitMem) begin
      repeat (waits) begin seqState.push_back(s); seqRdy.push_back(1'b0); end
      seqState.push_back(s);
      seqRdy.push_back(1'b1);
    end else begin
      pushPlain(s);
    end
  endtask

  task automatic buildSeq(input logic [6:0] o, input logic [2:0] f3, input int fw, input int mw);
    seqState.delete();
    seqRdy.delete();
    pushMem(FETCH, fw);
    pushPlain(DECODE);
    if (o == 7'b0000011) begin
      pushPlain(MEMADR); pushMem(MEMREAD, mw); pushPlain(MEMWB);
    end else if (o == 7'b0100011) begin
      pushPlain(MEMADR); pushMem(MEMWRITE, mw);
    end else if (o == 7'b0110011) begin
      pushPlain(EXECR); pushPlain(ALUWB);
    end else if (o == 7'b0010011) begin
      pushPlain(EXECI); pushPlain(ALUWB);
    end else if (o == 7'b1100011) begin
      pushPlain(BRANCH);
      if (f3 > 1) repeat (10) pushPlain(TRAP);
    end else if (o == 7'b1101111 && mEnJal) begin
      pushPlain(JAL); pushPlain(ALUWB);
    end else if (o == 7'b0110111 && mEnLui) begin
      pushPlain(LUI); pushPlain(ALUWB);
    end else begin
      repeat (10) pushPlain(TRAP);
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b1;
    memReady = 1'($urandom_range(0, 1));
    #1;
    checkOutput("resetOuts", useB ? 32'(bOuts) : 32'(aOuts),
                32'(expOuts(FETCH, memReady, zero, funct3)));
    @(posedge clk);
    modelRetired = '0;
  endtask

  task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3, input bit z,
                               input int fw, input int mw, input int limit);
    int n;
    buildSeq(o, f3, fw, mw);
    n = (seqState.size() < limit) ? seqState.size() : limit;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset = 1'b0;
      if (i == 0) begin op = o; funct3 = f3; zero = z; end
      memReady = seqRdy[i];
      #1;
      checkOutput("state", useB ? 32'(bState) : 32'(aState), 32'(seqState[i]));
      checkOutput("strobes", useB ? 32'(bOuts) : 32'(aOuts),
                  32'(expOuts(seqState[i], seqRdy[i], z, f3)));
      checkOutput("illegal", useB ? 32'(bIllegal) : 32'(aIllegal), 32'(seqState[i] == TRAP));
      checkOutput("retired", useB ? 32'(bRetired) : aRetired, modelRetired);
    end
    if (n < seqState.size() || seqState[n-1] == TRAP) begin
      applyReset();
    end else begin
      modelRetired = (modelRetired + 1) & mMask;
    end
  endtask

  task automatic randomInstr(input int fwMax);
    logic [6:0] o;
    logic [2:0] f3;
    case ($urandom_range(0, 9))
      0: o = 7'b0000011;
      1: o = 7'b0100011;
      2, 9: o = 7'b0110011;
      3: o = 7'b0010011;
      4, 8: o = 7'b1100011;
      5: o = 7'b1101111;
      6: o = 7'b0110111;
      default: o = 7'($urandom_range(0, 127));
    endcase
    f3 = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 1));
    applyStimulus(o, f3, 1'($urandom_range(0, 1)), $urandom_range(0, fwMax),
                  $urandom_range(0, 3), 1000);
  endtask

  initial begin
    // Default configuration instance.
    useB = 0; mWaitMem = 1; mEnJal = 1; mEnLui = 1; mMask = 32'hFFFF_FFFF;
    applyReset();
    applyStimulus(7'b0110011, 3'd0, 1'b0, 0, 0, 1000);
    applyStimulus(7'b0000011, 3'd0, 1'b0, 0, 3, 1000);
    applyStimulus(7'b0100011, 3'd0, 1'b0, 2, 2, 1000);
    applyStimulus(7'b1100011, 3'd1, 1'b0, 0, 0, 1000);
    applyStimulus(7'b1100011, 3'd1, 1'b1, 0, 0, 1000);
    applyStimulus(7'b1100011, 3'd0, 1'b1, 0, 0, 1000);
    applyStimulus(7'b0110111, 3'd0, 1'b0, 0, 0, 1000);
    applyStimulus(7'b1101111, 3'd0, 1'b0, 0, 0, 1000);
    applyStimulus(7'b0010011, 3'd0, 1'b0, 1, 0, 1000);
    applyStimulus(7'b0000000, 3'd0, 1'b0, 0, 0, 1000);
    applyStimulus(7'b0110011, 3'd0, 1'b0, 0, 0, 1000);
    applyStimulus(7'b0000011, 3'd0, 1'b0, 0, 3, 4);
    applyStimulus(7'b1100011, 3'd5, 1'b0, 0, 0, 1000);
    repeat (60) randomInstr(2);

    // Single-cycle memory, no jal/lui, 4-bit counter instance.
    @(negedge clk);
    useB = 1; mWaitMem = 0; mEnJal = 0; mEnLui = 0; mMask = 32'h0000_000F;
    applyReset();
    applyStimulus(7'b0110111, 3'd0, 1'b0, 0, 0, 1000);
    repeat (18) applyStimulus(7'b0110011, 3'd0, 1'b0, 0, 0, 1000);
    applyStimulus(7'b0000011, 3'd0, 1'b0, 0, 0, 1000);
    applyStimulus(7'b0100011, 3'd0, 1'b0, 0, 0, 1000);
    applyStimulus(7'b1101111, 3'd0, 1'b0, 0, 0, 1000);
    repeat (40) randomInstr(0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
